// File: rtl/iob_ila_dump_pkg.sv
// Shared types and constants for the ILA dump engine: FSM encodings,
// header marker and the words-per-sample helper.
package iob_ila_dump_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_NS,
    ST_WAIT_NS,
    ST_WR_IDX,
    ST_WR_SEL,
    ST_RD_DAT,
    ST_WAIT_DAT,
    ST_PUSH,
    ST_DONE
`ifdef IOB_ILA_DUMP_HEADER_EN
    , ST_HDR
`endif
  } state_t;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_REQ,
    ACC_WAIT_RV
  } acc_state_t;

  localparam logic [15:0] HDR_MARKER = 16'hA1A0;

  function automatic int n_words(input int signal_w, input int data_w);
    return (signal_w + data_w - 1) / data_w;
  endfunction

endpackage

// File: rtl/iob_ila_dump_acc.sv
// Single IOb-native access engine: latches one request on start_i, holds it
// until ready, waits for rvalid on reads, then pulses done_o.
module iob_ila_dump_acc #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cke_i,
  input  logic                start_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                iob_avalid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_ready_i,
  input  logic                iob_rvalid_i,
  input  logic [DATA_W-1:0]   iob_rdata_i
);
  import iob_ila_dump_pkg::*;

  acc_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ACC_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else if (cke_i) begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    done_o  = 1'b0;
    case (state_q)
      ACC_IDLE: begin
        if (start_i) begin
          state_d = ACC_REQ;
          addr_d  = addr_i;
          wdata_d = we_i ? wdata_i : '0;
          we_d    = we_i;
        end
      end
      ACC_REQ: begin
        // request fields drop to zero once accepted so the bus idles clean
        if (iob_ready_i) begin
          state_d = we_q ? ACC_IDLE : ACC_WAIT_RV;
          done_o  = we_q;
          addr_d  = '0;
          wdata_d = '0;
          we_d    = 1'b0;
        end
      end
      ACC_WAIT_RV: begin
        if (iob_rvalid_i) begin
          state_d = ACC_IDLE;
          done_o  = 1'b1;
        end
      end
      default: state_d = ACC_IDLE;
    endcase
  end

  assign busy_o       = (state_q != ACC_IDLE);
  assign rdata_o      = iob_rdata_i;
  assign iob_avalid_o = (state_q == ACC_REQ);
  assign iob_addr_o   = addr_q;
  assign iob_wdata_o  = wdata_q;
  assign iob_wstrb_o  = (state_q == ACC_REQ && we_q) ? '1 : '0;

endmodule

// File: rtl/iob_ila_dump.sv
// ILA dump master: reads the sample count, walks every sample/word through the
// ILA registers and streams them out. IOB_ILA_DUMP_HEADER_EN adds a header word.
//
// state    | meaning
// IDLE     | waiting for start_i
// RD_NS    | issue read of N_SAMPLES
// WAIT_NS  | wait for sample count, latch ns
// HDR      | (header build only) stream {A1A0, ns}
// WR_IDX   | write sample index i
// WR_SEL   | write word select w
// RD_DAT   | issue read of SAMPLE_DATA
// WAIT_DAT | wait for sample word, capture it
// PUSH     | hold word on stream until accepted
// DONE     | one-cycle done pulse
module iob_ila_dump #(
  parameter int                ADDR_W             = 16,
  parameter int                DATA_W             = 32,
  parameter int                SIGNAL_W           = 32,
  parameter int                BUFFER_W           = 10,
  parameter logic [ADDR_W-1:0] INDEX_ADDR         = ADDR_W'('h10),
  parameter logic [ADDR_W-1:0] SIGNAL_SELECT_ADDR = ADDR_W'('h14),
  parameter logic [ADDR_W-1:0] SAMPLE_DATA_ADDR   = ADDR_W'('h18),
  parameter logic [ADDR_W-1:0] N_SAMPLES_ADDR     = ADDR_W'('h1C)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cke_i,
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                iob_avalid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_ready_i,
  input  logic                iob_rvalid_i,
  input  logic [DATA_W-1:0]   iob_rdata_i,
  output logic [DATA_W-1:0]   m_tdata_o,
  output logic                m_tvalid_o,
  input  logic                m_tready_i,
  output logic                m_tlast_o
);
  import iob_ila_dump_pkg::*;

  localparam int             N_WORDS = n_words(SIGNAL_W, DATA_W);
  localparam int             W_W     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [W_W-1:0] W_LAST  = W_W'(N_WORDS - 1);

  state_t              state_q, state_d;
  logic [BUFFER_W-1:0] ns_q, ns_d;
  logic [BUFFER_W:0]   i_q, i_d;
  logic [W_W-1:0]      w_q, w_d;
  logic [DATA_W-1:0]   word_q, word_d;

  logic                acc_start, acc_we, acc_busy, acc_done;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata, acc_rdata;
  logic                last_i, last_word;

  iob_ila_dump_acc #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_acc (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cke_i       (cke_i),
    .start_i     (acc_start),
    .we_i        (acc_we),
    .addr_i      (acc_addr),
    .wdata_i     (acc_wdata),
    .busy_o      (acc_busy),
    .done_o      (acc_done),
    .rdata_o     (acc_rdata),
    .iob_avalid_o(iob_avalid_o),
    .iob_addr_o  (iob_addr_o),
    .iob_wdata_o (iob_wdata_o),
    .iob_wstrb_o (iob_wstrb_o),
    .iob_ready_i (iob_ready_i),
    .iob_rvalid_i(iob_rvalid_i),
    .iob_rdata_i (iob_rdata_i)
  );

  // i is one bit wider than ns so the final index never aliases
  assign last_i    = ((i_q + 1'b1) == {1'b0, ns_q});
  assign last_word = last_i && (w_q == W_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ns_q    <= '0;
      i_q     <= '0;
      w_q     <= '0;
      word_q  <= '0;
    end else if (cke_i) begin
      state_q <= state_d;
      ns_q    <= ns_d;
      i_q     <= i_d;
      w_q     <= w_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ns_d      = ns_q;
    i_d       = i_q;
    w_d       = w_q;
    word_d    = word_q;
    acc_start = 1'b0;
    acc_we    = 1'b0;
    acc_addr  = '0;
    acc_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_RD_NS;
      end
      ST_RD_NS: begin
        acc_start = 1'b1;
        acc_addr  = N_SAMPLES_ADDR;
        state_d   = ST_WAIT_NS;
      end
      ST_WAIT_NS: begin
        if (acc_done) begin
          ns_d = acc_rdata[BUFFER_W-1:0];
          i_d  = '0;
          w_d  = '0;
`ifdef IOB_ILA_DUMP_HEADER_EN
          state_d = ST_HDR;
`else
          state_d = (acc_rdata[BUFFER_W-1:0] == '0) ? ST_DONE : ST_WR_IDX;
`endif
        end
      end
`ifdef IOB_ILA_DUMP_HEADER_EN
      ST_HDR: begin
        if (m_tready_i) state_d = (ns_q == '0) ? ST_DONE : ST_WR_IDX;
      end
`endif
      ST_WR_IDX: begin
        acc_start = !acc_busy;
        acc_we    = 1'b1;
        acc_addr  = INDEX_ADDR;
        acc_wdata = DATA_W'(i_q);
        if (acc_done) state_d = ST_WR_SEL;
      end
      ST_WR_SEL: begin
        acc_start = !acc_busy;
        acc_we    = 1'b1;
        acc_addr  = SIGNAL_SELECT_ADDR;
        acc_wdata = DATA_W'(w_q);
        if (acc_done) state_d = ST_RD_DAT;
      end
      ST_RD_DAT: begin
        acc_start = 1'b1;
        acc_addr  = SAMPLE_DATA_ADDR;
        state_d   = ST_WAIT_DAT;
      end
      ST_WAIT_DAT: begin
        if (acc_done) begin
          word_d  = acc_rdata;
          state_d = ST_PUSH;
        end
      end
      ST_PUSH: begin
        if (m_tready_i) begin
          if (w_q == W_LAST) begin
            w_d = '0;
            if (last_i) begin
              state_d = ST_DONE;
            end else begin
              i_d     = i_q + 1'b1;
              state_d = ST_WR_IDX;
            end
          end else begin
            w_d     = w_q + 1'b1;
            state_d = ST_WR_SEL;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    m_tvalid_o = 1'b0;
    m_tdata_o  = '0;
    m_tlast_o  = 1'b0;
    if (state_q == ST_PUSH) begin
      m_tvalid_o = 1'b1;
      m_tdata_o  = word_q;
      m_tlast_o  = last_word;
    end
`ifdef IOB_ILA_DUMP_HEADER_EN
    if (state_q == ST_HDR) begin
      m_tvalid_o = 1'b1;
      m_tdata_o  = DATA_W'({HDR_MARKER, 16'(ns_q)});
      m_tlast_o  = (ns_q == '0);
    end
`endif
  end

  assign busy_o = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_iob_ila_dump.sv
// Directed bench for iob_ila_dump: two instances (32-bit and 72-bit samples)
// each with a behavioural ILA register slave and a stream/bus monitor.
module tb_iob_ila_dump;

  localparam logic [15:0] A_IDX = 16'h10;
  localparam logic [15:0] A_SEL = 16'h14;
  localparam logic [15:0] A_DAT = 16'h18;
  localparam logic [15:0] A_NS  = 16'h1C;
`ifdef IOB_ILA_DUMP_HEADER_EN
  localparam int HOFS = 1;
`else
  localparam int HOFS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cke = 1'b1;
  logic        log_clr = 1'b0;
  logic        ready_en = 1'b1;
  int          ready_lat = 1;
  logic [1:0]  start = 2'b00;
  logic [1:0]  tready = 2'b00;
  logic [31:0] ns_val [2];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] sample(input int idx, input int sel);
    return 32'hC000_0000 | 32'(idx << 8) | 32'(sel);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int SW = (g == 0) ? 32 : 72;
    logic        avalid, ready, rvalid, busy, done, tvalid, tlast;
    logic [15:0] addr;
    logic [31:0] wdata, rdata, tdata;
    logic [3:0]  wstrb;
    int          age;
    logic [31:0] idx_reg, sel_reg;
    int          wr_n, words_n, done_n, stab_err, stall_req, last_n, last_at;
    logic [15:0] wr_addr [64];
    logic [31:0] wr_data [64];
    logic [31:0] word [64];
    logic        word_last [64];
    logic        p_avalid, p_ready, p_tvalid, p_tready;
    logic [15:0] p_addr;
    logic [31:0] p_wdata, p_tdata;
    logic [3:0]  p_wstrb;

    assign ready = avalid && ready_en && (age >= ready_lat);

    iob_ila_dump #(.SIGNAL_W(SW)) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .cke_i       (cke),
      .start_i     (start[g]),
      .busy_o      (busy),
      .done_o      (done),
      .iob_avalid_o(avalid),
      .iob_addr_o  (addr),
      .iob_wdata_o (wdata),
      .iob_wstrb_o (wstrb),
      .iob_ready_i (ready),
      .iob_rvalid_i(rvalid),
      .iob_rdata_i (rdata),
      .m_tdata_o   (tdata),
      .m_tvalid_o  (tvalid),
      .m_tready_i  (tready[g]),
      .m_tlast_o   (tlast)
    );

    // register slave: rvalid one cycle after an accepted read
    always @(posedge clk) begin
      if (rst) begin
        age <= 0; rvalid <= 1'b0; rdata <= 32'h0; idx_reg <= 32'h0; sel_reg <= 32'h0;
      end else begin
        age    <= (avalid && !ready) ? age + 1 : 0;
        rvalid <= 1'b0;
        rdata  <= 32'h0;
        if (avalid && ready) begin
          if (wstrb != 4'h0) begin
            if (addr == A_IDX) idx_reg <= wdata;
            if (addr == A_SEL) sel_reg <= wdata;
          end else begin
            rvalid <= 1'b1;
            if (addr == A_NS) rdata <= ns_val[g];
            else if (addr == A_DAT) rdata <= sample(int'(idx_reg), int'(sel_reg));
          end
        end
      end
    end

    always @(posedge clk) begin
      p_avalid <= avalid && !rst;
      p_ready  <= ready;
      p_addr   <= addr;
      p_wdata  <= wdata;
      p_wstrb  <= wstrb;
      p_tvalid <= tvalid && !rst;
      p_tready <= tready[g];
      p_tdata  <= tdata;
      if (log_clr) begin
        wr_n <= 0; words_n <= 0; done_n <= 0; stab_err <= 0;
        stall_req <= 0; last_n <= 0; last_at <= -1;
      end else begin
        if (avalid && ready && wstrb != 4'h0) begin
          if (wr_n < 64) begin
            wr_addr[wr_n] <= addr;
            wr_data[wr_n] <= wdata;
          end
          wr_n <= wr_n + 1;
        end
        if (tvalid && tready[g]) begin
          if (words_n < 64) begin
            word[words_n]      <= tdata;
            word_last[words_n] <= tlast;
          end
          words_n <= words_n + 1;
          if (tlast) begin
            last_n  <= last_n + 1;
            last_at <= words_n;
          end
        end
        if (done) done_n <= done_n + 1;
        if (tvalid && avalid) stall_req <= stall_req + 1;
        if (!rst && p_avalid && !p_ready &&
            !(avalid && addr == p_addr && wdata == p_wdata && wstrb == p_wstrb))
          stab_err <= stab_err + 1;
        if (!rst && p_avalid && p_ready && avalid) stab_err <= stab_err + 1;
        if (!rst && p_tvalid && !p_tready && !(tvalid && tdata == p_tdata))
          stab_err <= stab_err + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic done_of(input int g);
    return (g == 0) ? g_dut[0].done : g_dut[1].done;
  endfunction

  function automatic logic [127:0] outs(input int g);
    if (g == 0)
      return {39'b0, g_dut[0].busy, g_dut[0].done, g_dut[0].avalid, g_dut[0].tvalid,
              g_dut[0].tlast, g_dut[0].addr, g_dut[0].wdata, g_dut[0].wstrb, g_dut[0].tdata};
    return {39'b0, g_dut[1].busy, g_dut[1].done, g_dut[1].avalid, g_dut[1].tvalid,
            g_dut[1].tlast, g_dut[1].addr, g_dut[1].wdata, g_dut[1].wstrb, g_dut[1].tdata};
  endfunction

  task automatic clear_logs();
    log_clr = 1'b1;
    tick();
    log_clr = 1'b0;
  endtask

  task automatic pulse_start(input int g);
    start[g] = 1'b1;
    tick();
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int g, input int budget, output int cycles);
    cycles = 0;
    while (!done_of(g) && cycles < budget) begin
      tick();
      cycles++;
    end
    check(tag, 128'(cycles < budget), 128'(1));
    tick();
  endtask

  initial begin
    int          cyc;
    int          n;
    int          bad;
    int          chg;
    logic [23:0] selseq;
    logic [5:0]  lastv;
    logic [15:0] a0;
    logic [31:0] w0, d0, d_exp;
    logic [3:0]  s0;

    ns_val[0] = 32'h0;
    ns_val[1] = 32'h0;
    repeat (3) tick();
    check("reset_outs0", outs(0), 128'(0));
    check("reset_outs1", outs(1), 128'(0));
    rst = 1'b0;
    clear_logs();

    // start while clock enable is low must be lost
    cke = 1'b0;
    pulse_start(0);
    repeat (3) tick();
    check("cke_low_busy", 128'(g_dut[0].busy), 128'(0));
    cke = 1'b1;
    tick();

    // three samples, one word each
    ns_val[0] = 32'd3;
    tready = 2'b11;
    clear_logs();
    pulse_start(0);
    wait_done("a_done", 0, 300, cyc);
    check("a_wr_n", 128'(g_dut[0].wr_n), 128'(6));
    check("a_wr_addr", {g_dut[0].wr_addr[0], g_dut[0].wr_addr[1], g_dut[0].wr_addr[2],
                        g_dut[0].wr_addr[3], g_dut[0].wr_addr[4], g_dut[0].wr_addr[5]},
          {A_IDX, A_SEL, A_IDX, A_SEL, A_IDX, A_SEL});
    check("a_idx_data", {g_dut[0].wr_data[0], g_dut[0].wr_data[2], g_dut[0].wr_data[4]},
          {32'd0, 32'd1, 32'd2});
    check("a_sel_data", {g_dut[0].wr_data[1], g_dut[0].wr_data[3], g_dut[0].wr_data[5]}, 128'(0));
    check("a_words_n", 128'(g_dut[0].words_n), 128'(3 + HOFS));
    check("a_words", {g_dut[0].word[HOFS], g_dut[0].word[HOFS+1], g_dut[0].word[HOFS+2]},
          {sample(0, 0), sample(1, 0), sample(2, 0)});
    check("a_tlast", {g_dut[0].word_last[HOFS+2], g_dut[0].word_last[HOFS+1],
                      g_dut[0].word_last[HOFS]}, 128'(3'b100));
    check("a_done_n", 128'(g_dut[0].done_n), 128'(1));
`ifdef IOB_ILA_DUMP_HEADER_EN
    check("a_hdr", {g_dut[0].word_last[0], g_dut[0].word[0]}, {1'b0, 32'hA1A0_0003});
`endif

    // 72-bit samples: three words each
    ns_val[1] = 32'd2;
    clear_logs();
    pulse_start(1);
    wait_done("b_done", 1, 400, cyc);
    check("b_wr_n", 128'(g_dut[1].wr_n), 128'(8));
    selseq = 24'h0;
    for (int k = 0; k < 8; k++)
      if (g_dut[1].wr_addr[k] == A_SEL) selseq = {selseq[19:0], g_dut[1].wr_data[k][3:0]};
    check("b_sel_seq", 128'(selseq), 128'(24'h012012));
    check("b_words_n", 128'(g_dut[1].words_n), 128'(6 + HOFS));
    bad = 0;
    lastv = 6'b0;
    for (int k = 0; k < 6; k++) begin
      if (g_dut[1].word[HOFS+k] !== sample(k / 3, k % 3)) bad++;
      lastv[k] = g_dut[1].word_last[HOFS+k];
    end
    check("b_words", 128'(bad), 128'(0));
    check("b_tlast", 128'(lastv), 128'(6'b100000));

    // empty buffer
    ns_val[0] = 32'd0;
    clear_logs();
    pulse_start(0);
    wait_done("c_done", 0, 50, cyc);
    check("c_latency_ok", 128'(cyc >= 3 && cyc <= 5), 128'(1));
    check("c_wr_n", 128'(g_dut[0].wr_n), 128'(0));
`ifdef IOB_ILA_DUMP_HEADER_EN
    check("c_words_n", 128'(g_dut[0].words_n), 128'(1));
    check("c_hdr", {g_dut[0].word_last[0], g_dut[0].word[0]}, {1'b1, 32'hA1A0_0000});
`else
    check("c_words_n", 128'(g_dut[0].words_n), 128'(0));
`endif

    // consumer stall of 10 cycles; upper count bits must be ignored
    ns_val[0] = 32'h0000_0402;
    tready[0] = 1'b0;
    clear_logs();
    pulse_start(0);
    n = 0;
    while (!g_dut[0].tvalid && n < 200) begin tick(); n++; end
    check("d_tvalid_seen", 128'(n < 200), 128'(1));
    d0 = g_dut[0].tdata;
`ifdef IOB_ILA_DUMP_HEADER_EN
    d_exp = 32'hA1A0_0002;
`else
    d_exp = sample(0, 0);
`endif
    check("d_first_tdata", 128'(d0), 128'(d_exp));
    chg = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!g_dut[0].tvalid || g_dut[0].tdata !== d0 || g_dut[0].avalid) chg++;
    end
    check("d_stall_hold", 128'(chg), 128'(0));
    tready[0] = 1'b1;
    wait_done("d_done", 0, 300, cyc);
    check("d_words_n", 128'(g_dut[0].words_n), 128'(2 + HOFS));
    check("d_words", {g_dut[0].word[HOFS], g_dut[0].word[HOFS+1]}, {sample(0, 0), sample(1, 0)});
    check("d_last_at", 128'(g_dut[0].last_at), 128'(1 + HOFS));
    check("d_stall_req", 128'(g_dut[0].stall_req), 128'(0));

    // reset while a select write is pending
    ns_val[1] = 32'd2;
    clear_logs();
    pulse_start(1);
    n = 0;
    while (!(g_dut[1].avalid && g_dut[1].addr == A_SEL) && n < 200) begin tick(); n++; end
    check("e_sel_seen", 128'(n < 200), 128'(1));
    rst = 1'b1;
    tick();
    check("e_rst_outs", outs(1), 128'(0));
    rst = 1'b0;
    tick();
    clear_logs();
    pulse_start(1);
    wait_done("e_done", 1, 400, cyc);
    check("e_words_n", 128'(g_dut[1].words_n), 128'(6 + HOFS));
    bad = 0;
    for (int k = 0; k < 6; k++)
      if (g_dut[1].word[HOFS+k] !== sample(k / 3, k % 3)) bad++;
    check("e_words", 128'(bad), 128'(0));
    check("e_done_n", 128'(g_dut[1].done_n), 128'(1));

    // bus stall of 20 cycles on the index write, plus a stray start
    ns_val[0] = 32'd1;
    clear_logs();
    pulse_start(0);
    n = 0;
    while (!(g_dut[0].avalid && g_dut[0].addr == A_IDX) && n < 200) begin tick(); n++; end
    check("f_idx_seen", 128'(n < 200), 128'(1));
    ready_en = 1'b0;
    a0 = g_dut[0].addr;
    w0 = g_dut[0].wdata;
    s0 = g_dut[0].wstrb;
    check("f_req_fields", {a0, w0, s0}, {A_IDX, 32'd0, 4'hF});
    chg = 0;
    for (int k = 0; k < 20; k++) begin
      start[0] = (k == 5);
      tick();
      if (!g_dut[0].avalid || g_dut[0].addr !== a0 || g_dut[0].wdata !== w0 ||
          g_dut[0].wstrb !== s0) chg++;
    end
    start[0] = 1'b0;
    check("f_stall_hold", 128'(chg), 128'(0));
    ready_en = 1'b1;
    wait_done("f_done", 0, 300, cyc);
    repeat (20) tick();
    check("f_busy_after", 128'(g_dut[0].busy), 128'(0));
    check("f_words", {96'(g_dut[0].words_n), g_dut[0].word[HOFS]}, {96'(1 + HOFS), sample(0, 0)});
    check("f_done_n", 128'(g_dut[0].done_n), 128'(1));
    check("f_stab_err", 128'(g_dut[0].stab_err + g_dut[1].stab_err), 128'(0));

    // largest sample count, zero-wait slave
    ready_lat = 0;
    ns_val[0] = 32'd1023;
    clear_logs();
    pulse_start(0);
    wait_done("g_done", 0, 20000, cyc);
    check("g_words_n", 128'(g_dut[0].words_n), 128'(1023 + HOFS));
    check("g_wr_n", 128'(g_dut[0].wr_n), 128'(2046));
    check("g_last", {64'(g_dut[0].last_n), 64'(g_dut[0].last_at)}, {64'(1), 64'(1022 + HOFS)});
    check("g_done_n", 128'(g_dut[0].done_n), 128'(1));
    check("g_stab_err", 128'(g_dut[0].stab_err), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
